sprite_fetch_arbiter: RTL and testbench

SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_fetch_arbiter_rr.sv | 93 +++++++++
 rtl/sprite_fetch_arbiter.sv | 100 ++++++++++
 tb/tb_sprite_fetch_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// ----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite memory path: default address/data widths,
// the 8:8:8 RGB pixel type, the transparent-colour key, and a small helper for
// sizing requester-index fields.
// No ports (package).
// ----------------------------------------------------------------------------
package sprite_pkg;

    localparam int SPRITE_ADDR_W = 15;
    localparam int SPRITE_DATA_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Magenta is the colour key the sprite engine treats as "no pixel".
    localparam pixel_t TRANSPARENT_PIXEL = '{r: 8'hFF, g: 8'h00, b: 8'hFF};

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_fetch_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational next-winner select over NUM_REQ requests plus the registered
// round-robin pointer. The search starts at the pointer; after a taken grant
// to index k the pointer moves to k+1, wrapping to 0.
// Build option: define ARB_FIXED_PRIORITY_EN to replace round-robin with fixed
// priority (index 0 highest); the pointer register is then not built.
// Ports:
//   Clk      sole clock
//   Reset    synchronous, active-low
//   req      per-requester request vector
//   advance  the current winner is actually being granted this cycle
//   gnt      one-hot winner (all zero when no request)
//   gnt_idx  binary index of the winner
//   any      at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    logic [IDX_W-1:0] k;

`ifdef ARB_FIXED_PRIORITY_EN

    // Clock, reset and advance only matter for the pointer, which this build
    // does not have.
    logic unused_fixed;
    assign unused_fixed = &{1'b0, Clk, Reset, advance};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        k       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IDX_W'(i);
            if (!any && req[k]) begin
                gnt[k]  = 1'b1;
                gnt_idx = k;
                any     = 1'b1;
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        k       = '0;
        // Visit requesters in the order ptr, ptr+1, ... wrapping modulo
        // NUM_REQ; the first one requesting wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[k]) begin
                gnt[k]  = 1'b1;
                gnt_idx = k;
                any     = 1'b1;
            end
        end
    end

    // Pointer only moves when a grant is really issued, so idle cycles and
    // write-priority cycles leave it untouched.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!Reset) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

`endif

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// sprite_fetch_arbiter
// Shares one synchronous sprite memory between NUM_REQ read requesters and a
// single sprite-update write port. Writes have absolute priority; reads are
// round-robin (or fixed priority with ARB_FIXED_PRIORITY_EN defined).
// Timing: requests sampled in cycle T, grant and memory address registered in
// T+1, rsp_valid in T+2 alongside the memory's read data.
// Ports:
//   Clk, Reset                         clock, synchronous active-low reset
//   rd_req, rd_addr                    per-requester read request/address
//   rd_gnt                             one-hot grant pulse
//   rsp_valid, rsp_data                one-hot response marker, shared pixel
//   wr_req, wr_addr, wr_data           sprite update write request
//   wr_gnt                             write accepted pulse
//   mem_read_address, mem_write_address, mem_data_In, mem_we   to memory
//   mem_data_Out                       memory read data (1-cycle latency)
// Build option: ARB_FIXED_PRIORITY_EN (see rr_arbiter).
// ----------------------------------------------------------------------------
module sprite_fetch_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SPRITE_ADDR_W,
    parameter int DATA_W  = SPRITE_DATA_W
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             rd_req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] rd_addr,
    output logic [NUM_REQ-1:0]             rd_gnt,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
    input  logic                           wr_req,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic                           wr_gnt,
    output logic [ADDR_W-1:0]              mem_read_address,
    output logic [ADDR_W-1:0]              mem_write_address,
    output logic [DATA_W-1:0]              mem_data_In,
    output logic                           mem_we,
    input  logic [DATA_W-1:0]              mem_data_Out
);

    localparam int IDX_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               rd_fire;

    // A pending write blocks the read winner; the blocked request stays
    // asserted and is re-arbitrated next cycle, by which time the write has
    // landed, so a same-address read returns the new data.
    assign rd_fire = arb_any && !wr_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .Clk     (Clk),
        .Reset   (Reset),
        .req     (rd_req),
        .advance (rd_fire),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge Clk) begin
        // NOTE: the memory address/data registers are cleared too, so the
        // memory never sees stale values after reset; the memory array itself
        // lives outside and is not reset.
        if (!Reset) begin
            rd_gnt            <= '0;
            wr_gnt            <= 1'b0;
            mem_we            <= 1'b0;
            rsp_valid         <= '0;
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_data_In       <= '0;
        end else begin
            wr_gnt    <= wr_req;
            mem_we    <= wr_req;
            rd_gnt    <= rd_fire ? arb_gnt : '0;
            // Response marker trails the grant by exactly the memory latency.
            rsp_valid <= rd_gnt;
            if (wr_req) begin
                mem_write_address <= wr_addr;
                mem_data_In       <= wr_data;
            end
            if (rd_fire) begin
                mem_read_address <= rd_addr[arb_idx];
            end
        end
    end

    // The memory's registered output lines up with rsp_valid.
    assign rsp_data = mem_data_Out;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
module tb_sprite_fetch_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 24;
    localparam int DEPTH   = 1 << ADDR_W;

    logic                           Clk = 1'b0;
    logic                           Reset;
    logic [NUM_REQ-1:0]             rd_req;
    logic [NUM_REQ-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_REQ-1:0]             rd_gnt;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_data;
    logic                           wr_req;
    logic [ADDR_W-1:0]              wr_addr;
    logic [DATA_W-1:0]              wr_data;
    logic                           wr_gnt;
    logic [ADDR_W-1:0]              mem_read_address;
    logic [ADDR_W-1:0]              mem_write_address;
    logic [DATA_W-1:0]              mem_data_In;
    logic                           mem_we;
    logic [DATA_W-1:0]              mem_data_Out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    sprite_fetch_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .rd_req            (rd_req),
        .rd_addr           (rd_addr),
        .rd_gnt            (rd_gnt),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .wr_req            (wr_req),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .wr_gnt            (wr_gnt),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_data_In       (mem_data_In),
        .mem_we            (mem_we),
        .mem_data_Out      (mem_data_Out)
    );

    // Sprite memory: synchronous write, registered read (old data on collision).
    logic [DATA_W-1:0] tb_mem [DEPTH];

    function automatic logic [DATA_W-1:0] init_val(input int i);
        if (i == 16) return 24'hAABBCC;
        return DATA_W'((i * 32'h010203) ^ 32'h5A5A5A);
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_val(i);
    end

    always @(posedge Clk) begin
        if (mem_we) tb_mem[mem_write_address] <= mem_data_In;
        mem_data_Out <= tb_mem[mem_read_address];
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0]  golden [DEPTH];
    logic [NUM_REQ-1:0] m_rd_gnt, m_rsp_valid;
    logic               m_wr_gnt;
    logic [ADDR_W-1:0]  m_ra, m_wa;
    logic [DATA_W-1:0]  m_wd, m_pend, m_rsp_data;
    int                 m_ptr;

    // Predicts what the DUT shows after the next rising edge, given the inputs
    // currently driven. Golden memory is updated when a write is accepted;
    // a read sees every write accepted before its grant.
    task automatic model_step();
        logic [1:0] k;
        if (!Reset) begin
            m_rd_gnt    = '0;
            m_rsp_valid = '0;
            m_wr_gnt    = 1'b0;
            m_ra        = '0;
            m_wa        = '0;
            m_wd        = '0;
            m_ptr       = 0;
        end else begin
            m_rsp_valid = m_rd_gnt;
            m_rsp_data  = m_pend;
            m_wr_gnt    = wr_req;
            m_rd_gnt    = '0;
            if (wr_req) begin
                m_wa            = wr_addr;
                m_wd            = wr_data;
                golden[wr_addr] = wr_data;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    k = 2'((m_ptr + i) % NUM_REQ);
                    if (rd_req[k]) begin
                        m_rd_gnt[k] = 1'b1;
                        m_ra        = rd_addr[k];
                        m_pend      = golden[rd_addr[k]];
`ifndef ARB_FIXED_PRIORITY_EN
                        m_ptr       = (int'(k) + 1) % NUM_REQ;
`endif
                        break;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("rd_gnt", 64'(rd_gnt), 64'(m_rd_gnt));
        check("wr_gnt", 64'(wr_gnt), 64'(m_wr_gnt));
        check("mem_we", 64'(mem_we), 64'(m_wr_gnt));
        check("mem_read_address", 64'(mem_read_address), 64'(m_ra));
        check("mem_write_address", 64'(mem_write_address), 64'(m_wa));
        check("mem_data_In", 64'(mem_data_In), 64'(m_wd));
        check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        check("rsp_onehot", 64'($countones(rsp_valid) <= 1), 64'(1));
        if (m_rsp_valid != '0) check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
    endtask

    // One clock: predict, let the edge happen, compare on the falling edge.
    task automatic cycle();
        model_step();
        @(negedge Clk);
        check_all();
    endtask

    task automatic idle_inputs();
        rd_req  = '0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) rd_addr[i] = ADDR_W'(i + 32);
    endtask

    logic [NUM_REQ-1:0] exp_gnt;

    initial begin
        for (int i = 0; i < DEPTH; i++) golden[i] = init_val(i);
        m_pend     = '0;
        m_rsp_data = '0;
        m_ptr      = 0;
        idle_inputs();
        Reset = 1'b0;

        // Reset state.
        cycle();
        cycle();
        check("reset_rd_gnt", 64'(rd_gnt), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));

        // Single request; first grant one cycle after reset release.
        Reset      = 1'b1;
        rd_req     = 4'b0010;
        rd_addr[1] = 15'h0010;
        cycle();
        check("single_gnt", 64'(rd_gnt), 64'(4'b0010));
        check("single_addr", 64'(mem_read_address), 64'(15'h0010));
        rd_req = '0;
        cycle();
        check("single_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
        check("single_rsp_data", 64'(rsp_data), 64'(24'hAABBCC));
        cycle();
        check("idle_rsp_valid", 64'(rsp_valid), 64'(0));
        check("idle_addr_hold", 64'(mem_read_address), 64'(15'h0010));

        // All requesters held: round-robin from index 0, no bubbles.
        Reset = 1'b0;
        cycle();
        Reset  = 1'b1;
        rd_req = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) rd_addr[i] = ADDR_W'(i + 1);
        for (int i = 0; i < 8; i++) begin
            cycle();
`ifndef ARB_FIXED_PRIORITY_EN
            exp_gnt = 4'(1 << (i % 4));
            check("rr_order", 64'(rd_gnt), 64'(exp_gnt));
`endif
        end

        // Reset mid-flight: responses vanish, pointer back to 0.
        Reset = 1'b0;
        cycle();
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_rd_gnt", 64'(rd_gnt), 64'(0));
        Reset = 1'b1;
        cycle();
        check("postrst_gnt", 64'(rd_gnt), 64'(4'b0001));
        rd_req = '0;
        cycle();
        cycle();

        // Write and same-address read in the same cycle.
        wr_req     = 1'b1;
        wr_addr    = 15'h0005;
        wr_data    = 24'h123456;
        rd_req     = 4'b0100;
        rd_addr[2] = 15'h0005;
        cycle();
        check("wr_first_gnt", 64'(wr_gnt), 64'(1));
        check("wr_first_rd_gnt", 64'(rd_gnt), 64'(0));
        wr_req = 1'b0;
        cycle();
        check("deferred_rd_gnt", 64'(rd_gnt), 64'(4'b0100));
        rd_req = '0;
        cycle();
        check("deferred_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        check("deferred_rsp_data", 64'(rsp_data), 64'(24'h123456));

`ifdef ARB_FIXED_PRIORITY_EN
        rd_req = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("fixed_gnt", 64'(rd_gnt), 64'(4'b0001));
        end
        rd_req = '0;
        cycle();
`endif

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            Reset   = ($urandom_range(0, 99) != 0);
            rd_req  = 4'($urandom_range(0, 15));
            wr_req  = ($urandom_range(0, 3) == 0);
            wr_addr = 15'($urandom_range(0, 15));
            wr_data = 24'($urandom);
            for (int i = 0; i < NUM_REQ; i++) rd_addr[i] = 15'($urandom_range(0, 15));
            cycle();
        end

        idle_inputs();
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
